// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Data-memory responder for the core's load/store port.
//               Accepts one RV32I load/store at a time, decodes width/sign
//               from funct3, applies byte-lane writes to an internal word
//               array and returns the result LATENCY cycles after accept.
//
//   Parameters  DEPTH      number of 32-bit words (word index = addr[31:2])
//               LATENCY    accept-to-rsp_valid cycles, 1..15
//   Ports       clk, rst (asynchronous, active-low)
//               req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//               rsp_valid/rsp_ready/rsp_rdata/rsp_err
//   Macro       DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses
//               return rsp_err instead of being aligned down.
//
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_idle;
    logic        w_commit;
    logic        w_we;
    logic [2:0]  w_funct3;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_legal;
    logic        w_in_range;
    logic        w_misalign;
    logic        w_err;
    logic [c_AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rsp_rdata;

    assign w_idle    = (r_state == c_IDLE);
    assign req_ready = w_idle;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // With LATENCY=1 the access happens on the accept edge itself, so the
    // live request inputs feed the decode; otherwise the captured copy does.
    assign w_we     = w_idle ? req_we     : r_we;
    assign w_funct3 = w_idle ? req_funct3 : r_funct3;
    assign w_addr   = w_idle ? req_addr   : r_addr;
    assign w_wdata  = w_idle ? req_wdata  : r_wdata;

    // The counter is loaded with LATENCY-1; the access commits on the edge
    // that takes it from 1 to 0, so RESP starts exactly LATENCY cycles after
    // the accept cycle.
    assign w_commit = (r_state == c_BUSY && r_cnt == 4'd1) ||
                      (w_idle && req_valid && (LATENCY == 1));

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_legal = 1'b0;
        if (w_we) begin
            w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                      (w_funct3 == 3'b010);
        end else begin
            w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                      (w_funct3 == 3'b010) || (w_funct3 == 3'b100) ||
                      (w_funct3 == 3'b101);
        end
    end

    assign w_in_range = (w_addr[31:2] < 30'(DEPTH));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                        ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
    // Misaligned accesses are aligned down by the lane selection below.
    assign w_misalign = 1'b0;
`endif

    assign w_err = !w_legal || !w_in_range || w_misalign;
    assign w_idx = w_addr[c_AW+1:2];

    // ------------------------------------------------------------- load path
    assign w_word = r_mem[w_idx];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (w_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    assign w_rsp_rdata = (w_we || w_err) ? 32'd0 : w_load;

    // ------------------------------------------------------------ store path
    always_comb begin
        case (w_funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << w_addr[1:0];
                w_wdata_rep = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = w_wdata;
            end
        endcase
    end

    // -------------------------------------------------------- FSM + storage
    // The memory array is written from the reset-qualified branch so that a
    // request presented while rst is low can never commit; the array itself
    // is never cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_commit && w_we && !w_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) begin
                        r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                    end
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (LATENCY == 1) begin
                            r_state     <= c_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= w_rsp_rdata;
                            r_err       <= w_err;
                        end else begin
                            r_state <= c_BUSY;
                            r_cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                c_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= c_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= w_rsp_rdata;
                        r_err       <= w_err;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= c_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rdata     <= 32'd0;
                        r_err       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_resp
// Description : Self-checking bench for dmem_resp. A byte-addressed memory
//               model predicts every response; directed cases plus random
//               loads/stores with random backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

    localparam int c_DEPTH = 1024;
    localparam int c_LAT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [7:0]  mem_b [4*c_DEPTH];
    logic [31:0] last_rd;
    logic        last_err;

    dmem_resp #(.DEPTH(c_DEPTH), .LATENCY(c_LAT)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Byte-level model: n-byte access at an address aligned down to n.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int n;
        int base;
        logic legal, inr, mis;
        logic [31:0] v;
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        inr   = (a / 4) < c_DEPTH;
        mis   = (a % n) != 0;
        err   = !legal || !inr;
`ifdef DMEM_MISALIGN_TRAP_EN
        err   = err || mis;
`endif
        rd = 32'd0;
        if (!err) begin
            base = int'(a - (a % n));
            if (we) begin
                for (int k = 0; k < n; k++) mem_b[base+k] = wd[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v = v | (32'(mem_b[base+k]) << (8*k));
                if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                rd = v;
            end
        end
    endfunction

    // Entered at the falling edge of the cycle after the accept cycle.
    task automatic collect(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int n;
        logic [31:0] e_rd;
        logic e_err;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(c_LAT));
        model(we, f3, a, wd, e_rd, e_err);
        chk("rdata", rsp_rdata, e_rd);
        chk("err", 32'(rsp_err), 32'(e_err));
        last_rd  = e_rd;
        last_err = e_err;
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        // Scramble the request bus: the captured copy must be used.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        collect(we, f3, a, wd, rd, err);
    endtask

    // Hold rsp_ready low for k cycles; response must stay put.
    task automatic hold(input int k);
        rsp_ready = 1'b0;
        repeat (k) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, last_rd);
            chk("hold_err", 32'(rsp_err), 32'(last_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;

        for (int i = 0; i < 4*c_DEPTH; i++) mem_b[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;

        // Word store/load
        issue(1'b1, 3'b010, 32'h10, 32'h8000_00FF, rd, e);
        issue(1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        chk("lw_10", rd, 32'h8000_00FF);
        chk("lw_10_err", 32'(e), 32'd0);

        // Byte store, signed/unsigned byte loads
        issue(1'b1, 3'b000, 32'h13, 32'h7777_77AB, rd, e);
        issue(1'b0, 3'b000, 32'h13, 32'h0, rd, e);
        chk("lb_13", rd, 32'hFFFF_FFAB);
        issue(1'b0, 3'b100, 32'h13, 32'h0, rd, e);
        chk("lbu_13", rd, 32'h0000_00AB);
        issue(1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        chk("lw_10_after_sb", rd, 32'hAB00_00FF);

        // Halfword store into upper lane
        issue(1'b1, 3'b010, 32'h20, 32'hFFFF_FFFF, rd, e);
        issue(1'b1, 3'b001, 32'h22, 32'h0000_1234, rd, e);
        issue(1'b0, 3'b010, 32'h20, 32'h0, rd, e);
        chk("lw_20", rd, 32'h1234_FFFF);
        issue(1'b0, 3'b001, 32'h22, 32'h0, rd, e);
        chk("lh_22", rd, 32'h0000_1234);

        // Errors: illegal load funct3, out-of-range, illegal store
        issue(1'b0, 3'b011, 32'h10, 32'h0, rd, e);
        chk("ld011_err", 32'(e), 32'd1);
        chk("ld011_rdata", rd, 32'd0);
        issue(1'b0, 3'b010, 32'(4*c_DEPTH), 32'h0, rd, e);
        chk("oor_err", 32'(e), 32'd1);
        issue(1'b1, 3'b011, 32'h10, 32'h0, rd, e);
        chk("st011_err", 32'(e), 32'd1);
        issue(1'b1, 3'b010, 32'(4*c_DEPTH), 32'h0, rd, e);
        issue(1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        chk("mem_unchanged", rd, 32'hAB00_00FF);

        // Backpressure with a second request pending
        issue(1'b0, 3'b001, 32'h20, 32'h0, rd, e);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b101;
        req_addr   = 32'h22;
        req_wdata  = 32'h0;
        hold(5);
        @(negedge clk);
        chk("bp_req_ready", 32'(req_ready), 32'd1);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        collect(1'b0, 3'b101, 32'h22, 32'h0, rd, e);
        chk("bp_lhu_22", rd, 32'h0000_1234);

        // Misaligned word load
        issue(1'b0, 3'b010, 32'h12, 32'h0, rd, e);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw_mis_err", 32'(e), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
`else
        chk("lw_mis_rdata", rd, 32'hAB00_00FF);
        chk("lw_mis_err", 32'(e), 32'd0);
`endif

        // Reset one cycle after a store accept: store must be dropped
        issue(1'b1, 3'b010, 32'h40, 32'h5A5A_0001, rd, e);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 3'b010, 32'h40, 32'h0, rd, e);
        chk("rst_store_dropped", rd, 32'h5A5A_0001);

        // Random phase: seed a window of words, then mixed traffic
        for (int w = 0; w < 32; w++) issue(1'b1, 3'b010, 32'(4*w), $urandom, rd, e);
        for (int t = 0; t < 200; t++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'(4*c_DEPTH + $urandom_range(0, 4095))
                                                : ($urandom | 32'h8000_0000);
            else
                a = 32'($urandom_range(0, 127));
            issue(we, f3, a, $urandom, rd, e);
            if ($urandom_range(0, 3) == 0) hold($urandom_range(1, 4));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
